// File: rtl/wb_accel_pkg.sv
// Shared types and constants for the Wishbone-to-accelerator scheduler.
// Address decode lives here so the top and any future bench see one definition.
package wb_accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_WAIT, S_LITE_WR, S_LITE_AR, S_LITE_R, S_PUSH, S_POP, S_ACK
  } state_e;

  typedef enum logic [2:0] {
    TGT_MEM, TGT_LITE, TGT_STREAM, TGT_STAT, TGT_UNMAPPED
  } target_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  localparam logic [11:0] MEM_BASE   = 12'h380;
  localparam logic [11:0] ACCEL_BASE = 12'h300;

  localparam logic [1:0] LANE_FIR = 2'd0;
  localparam logic [1:0] LANE_MM  = 2'd1;
  localparam logic [1:0] LANE_QS  = 2'd2;
  localparam logic [1:0] TO_LITE  = 2'd3;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          CNT_W        = 16;

  function automatic target_e decode_target(input logic [31:0] adr);
    target_e t;
    t = TGT_UNMAPPED;
    if (adr[31:20] == MEM_BASE) begin
      t = TGT_MEM;
    end else if (adr[31:20] == ACCEL_BASE) begin
      // The low half of page 0 belongs to the FIR config bus, the upper half to its stream.
      if (adr[11:8] == 4'h0 && !adr[7]) begin
        t = TGT_LITE;
      end else if (adr[11:10] == 2'b00 &&
                   (adr[9:8] == LANE_FIR || adr[9:8] == LANE_MM || adr[9:8] == LANE_QS)) begin
        t = TGT_STREAM;
      end else if (adr[11:8] == 4'hF) begin
        t = TGT_STAT;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// Wait-cycle counter: cleared by load, advances while enabled, stops at the limit.
// done is a registered-count compare, so it is glitch-free within a cycle.
module wb_wait_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_accel_sched.sv
// Wishbone slave that schedules single transactions onto memory, the FIR AXI-Lite
// config bus, or one of three accelerator stream lanes; all waits are bounded by a timeout.
module wb_accel_sched
  import wb_accel_pkg::*;
#(
  parameter int MEM_DELAY = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        awvalid,
  input  logic        awready,
  output logic [11:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic        arvalid,
  input  logic        arready,
  output logic [11:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  output logic [2:0]  ss_tvalid,
  output logic [2:0]  ss_tlast,
  output logic [31:0] ss_tdata,
  input  logic [2:0]  ss_tready,
  input  logic [2:0]  sm_tvalid,
  input  logic [95:0] sm_tdata,
  output logic [2:0]  sm_tready
);

  localparam int MEM_LIM_I = (MEM_DELAY > 0) ? MEM_DELAY - 1 : 0;
  localparam int TO_LIM_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] MEM_LIM = MEM_LIM_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TO_LIM  = TO_LIM_I[CNT_W-1:0];

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdat_q, rdat_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [3:0]  timeout_q, timeout_d;

  target_e          tgt;
  logic             cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_limit;
  logic [2:0]       lane_oh;
  logic [31:0]      lane_dat;
  logic             expired;
  logic [1:0]       to_idx;
  logic             busy;

  assign tgt      = decode_target(wbs_adr_i);
  assign lane_oh  = 3'b001 << lane_q;
  assign lane_dat = (lane_q == LANE_QS) ? sm_tdata[95:64] :
                    (lane_q == LANE_MM) ? sm_tdata[63:32] : sm_tdata[31:0];
  // An accelerator holding a result nobody has popped yet.
  assign busy     = |sm_tvalid;

  assign mem_addr  = req_q.adr;
  assign mem_wdata = req_q.dat;
  assign awaddr    = req_q.adr[11:0];
  assign araddr    = req_q.adr[11:0];
  assign wdata     = req_q.dat;
  assign ss_tdata  = req_q.dat;

  // Every state change restarts the wait budget for the next handshake.
  assign cnt_load  = (state_d != state_q);
  assign cnt_en    = (state_q != S_IDLE) && (state_q != S_ACK);
  assign cnt_limit = (state_q == S_MEM_WAIT) ? MEM_LIM : TO_LIM;

  wb_wait_counter #(.W(CNT_W)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    lane_d    = lane_q;
    rdat_d    = rdat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    timeout_d = timeout_q;
    expired   = 1'b0;
    to_idx    = TO_LITE;
    wbs_ack_o = 1'b0;
    wbs_dat_o = '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ss_tvalid = '0;
    ss_tlast  = '0;
    sm_tready = '0;

    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          req_d     = '{adr: wbs_adr_i, dat: wbs_dat_i, we: wbs_we_i, sel: wbs_sel_i};
          lane_d    = wbs_adr_i[9:8];
          rdat_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          unique case (tgt)
            TGT_MEM:    state_d = S_MEM_WAIT;
            TGT_LITE:   state_d = !wbs_we_i ? S_LITE_AR :
                                  (wbs_sel_i == 4'h0) ? S_ACK : S_LITE_WR;
            TGT_STREAM: state_d = !wbs_we_i ? S_POP :
                                  (wbs_sel_i == 4'h0) ? S_ACK : S_PUSH;
            TGT_STAT: begin
              if (wbs_we_i) timeout_d = timeout_q & ~wbs_dat_i[7:4];
              else          rdat_d    = {busy, 23'b0, timeout_q, 4'h0};
              state_d = S_ACK;
            end
            default:    state_d = S_ACK;
          endcase
        end
      end

      S_MEM_WAIT: begin
        mem_en = 1'b1;
        mem_we = req_q.we ? req_q.sel : 4'h0;
        if (cnt_done) begin
          rdat_d  = mem_rdata;
          state_d = S_ACK;
        end
      end

      S_LITE_WR: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = S_ACK;
        else if (cnt_done)         expired = 1'b1;
      end

      S_LITE_AR: begin
        arvalid = 1'b1;
        if (arready)       state_d = S_LITE_R;
        else if (cnt_done) expired = 1'b1;
      end

      S_LITE_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rdat_d  = rdata;
          state_d = S_ACK;
        end else if (cnt_done) begin
          expired = 1'b1;
        end
      end

      S_PUSH: begin
        ss_tvalid = lane_oh;
        ss_tlast  = req_q.adr[2] ? lane_oh : 3'b000;
        to_idx    = lane_q;
        if (|(ss_tready & lane_oh)) state_d = S_ACK;
        else if (cnt_done)          expired = 1'b1;
      end

      S_POP: begin
        to_idx = lane_q;
        if (|(sm_tvalid & lane_oh)) begin
          sm_tready = lane_oh;
          rdat_d    = lane_dat;
          state_d   = S_ACK;
        end else if (cnt_done) begin
          expired = 1'b1;
        end
      end

      S_ACK: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = rdat_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (expired) begin
      timeout_d[to_idx] = 1'b1;
      rdat_d            = TIMEOUT_DATA;
      state_d           = S_ACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      lane_q    <= '0;
      rdat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      timeout_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      lane_q    <= lane_d;
      rdat_q    <= rdat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_accel_sched.sv
// Directed bench for wb_accel_sched: one task per scenario, expected values hand-derived.
module tb_wb_accel_sched;
  import wb_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [2:0]  ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tready;
  logic [31:0] ss_tdata;
  logic [95:0] sm_tdata;

  int n_cmp = 0;
  int n_err = 0;
  int c_ack = 0, c_mem = 0, c_aw = 0, c_w = 0, c_ar = 0, c_r = 0;
  int c_ss[3] = '{default: 0};
  int c_sm[3] = '{default: 0};

  wb_accel_sched #(.MEM_DELAY(10), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wbs_ack_o) c_ack++;
    if (mem_en)    c_mem++;
    if (awvalid)   c_aw++;
    if (wvalid)    c_w++;
    if (arvalid)   c_ar++;
    if (rready)    c_r++;
    for (int i = 0; i < 3; i++) begin
      if (ss_tvalid[i]) c_ss[i]++;
      if (sm_tready[i]) c_sm[i]++;
    end
  end

  function automatic int hs_total();
    return c_mem + c_aw + c_w + c_ar + c_r + c_ss[0] + c_ss[1] + c_ss[2] + c_sm[0] + c_sm[1] + c_sm[2];
  endfunction

  // Issues one Wishbone cycle; lat = clock edges from request to ack (-1 if none within bound).
  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, output int lat, output logic [31:0] rd);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    lat = -1; rd = '0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        lat = i; rd = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    mem_rdata = 0; awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
    ss_tready = 0; sm_tvalid = 0; sm_tdata = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wbs_ack_o, mem_en, awvalid, wvalid, arvalid, rready} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 000000", {wbs_ack_o, mem_en, awvalid, wvalid, arvalid, rready});
    end
    n_cmp++;
    if ({ss_tvalid, sm_tready, mem_we} !== 10'b0) begin
      n_err++; $display("FAIL reset_lanes: got %b expected 0", {ss_tvalid, sm_tready, mem_we});
    end
    n_cmp++;
    if (wbs_dat_o !== 32'h0) begin
      n_err++; $display("FAIL reset_dat: got %h expected 00000000", wbs_dat_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_read();
    int lat; logic [31:0] rd, a_s; logic [3:0] we_s; int m0;
    mem_rdata = 32'h1234_5678;
    m0 = c_mem;
    fork
      wb_xfer(32'h3800_0010, 32'h0, 1'b0, 4'hF, lat, rd);
      begin @(posedge clk); #1; a_s = mem_addr; we_s = mem_we; end
    join
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL mem_rd_lat: got %0d expected 11", lat); end
    n_cmp++; if (rd !== 32'h1234_5678) begin n_err++; $display("FAIL mem_rd_dat: got %h expected 12345678", rd); end
    n_cmp++; if (c_mem - m0 !== 10) begin n_err++; $display("FAIL mem_en_cycles: got %0d expected 10", c_mem - m0); end
    n_cmp++; if (a_s !== 32'h3800_0010) begin n_err++; $display("FAIL mem_addr: got %h expected 38000010", a_s); end
    n_cmp++; if (we_s !== 4'h0) begin n_err++; $display("FAIL mem_we_rd: got %b expected 0000", we_s); end
    @(posedge clk); #1;
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL ack_single: got %b expected 0", wbs_ack_o); end
  endtask

  task automatic test_mem_write();
    int lat; logic [31:0] rd, wd_s; logic [3:0] we_s;
    fork
      wb_xfer(32'h3800_0020, 32'h0000_0055, 1'b1, 4'b0101, lat, rd);
      begin @(posedge clk); #1; wd_s = mem_wdata; we_s = mem_we; end
    join
    n_cmp++; if (lat !== 11) begin n_err++; $display("FAIL mem_wr_lat: got %0d expected 11", lat); end
    n_cmp++; if (we_s !== 4'b0101) begin n_err++; $display("FAIL mem_we_wr: got %b expected 0101", we_s); end
    n_cmp++; if (wd_s !== 32'h55) begin n_err++; $display("FAIL mem_wdata: got %h expected 00000055", wd_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_lite_write();
    int lat; logic [31:0] rd, wd_s; logic [11:0] aa_s; int aw0, w0, ack0, ln0;
    aw0 = c_aw; w0 = c_w; ack0 = c_ack;
    ln0 = c_ss[0] + c_ss[1] + c_ss[2] + c_sm[0] + c_sm[1] + c_sm[2];
    fork
      wb_xfer(32'h3000_0000, 32'h0000_00A5, 1'b1, 4'hF, lat, rd);
      begin
        @(posedge clk); #1; aa_s = awaddr; wd_s = wdata;
        @(posedge clk); #1; awready = 1'b1;
        @(posedge clk); #1; awready = 1'b0;
        @(posedge clk); #1; wready = 1'b1;
        @(posedge clk); #1; wready = 1'b0;
      end
    join
    @(posedge clk); #1;
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL lite_wr_lat: got %0d expected 5", lat); end
    n_cmp++; if (c_aw - aw0 !== 2) begin n_err++; $display("FAIL awvalid_cycles: got %0d expected 2", c_aw - aw0); end
    n_cmp++; if (c_w - w0 !== 4) begin n_err++; $display("FAIL wvalid_cycles: got %0d expected 4", c_w - w0); end
    n_cmp++; if (c_ack - ack0 !== 1) begin n_err++; $display("FAIL lite_wr_acks: got %0d expected 1", c_ack - ack0); end
    n_cmp++;
    if (c_ss[0] + c_ss[1] + c_ss[2] + c_sm[0] + c_sm[1] + c_sm[2] - ln0 !== 0) begin
      n_err++; $display("FAIL lite_wr_lanes: got %0d expected 0", c_ss[0] + c_ss[1] + c_ss[2] + c_sm[0] + c_sm[1] + c_sm[2] - ln0);
    end
    n_cmp++; if ({aa_s, wd_s} !== {12'h000, 32'hA5}) begin n_err++; $display("FAIL lite_wr_addr_dat: got %h/%h expected 000/000000a5", aa_s, wd_s); end
  endtask

  task automatic test_lite_read();
    int lat; logic [31:0] rd; logic [11:0] ar_s; int ar0, r0;
    ar0 = c_ar; r0 = c_r;
    fork
      wb_xfer(32'h3000_0010, 32'h0, 1'b0, 4'hF, lat, rd);
      begin
        @(posedge clk); #1; ar_s = araddr; arready = 1'b1;
        @(posedge clk); #1; arready = 1'b0;
        @(posedge clk); #1; rvalid = 1'b1; rdata = 32'hBEEF_0001;
        @(posedge clk); #1; rvalid = 1'b0; rdata = 32'h0;
      end
    join
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL lite_rd_lat: got %0d expected 4", lat); end
    n_cmp++; if (rd !== 32'hBEEF_0001) begin n_err++; $display("FAIL lite_rd_dat: got %h expected beef0001", rd); end
    n_cmp++; if (ar_s !== 12'h010) begin n_err++; $display("FAIL araddr: got %h expected 010", ar_s); end
    n_cmp++; if ({c_ar - ar0, c_r - r0} !== {32'd1, 32'd2}) begin n_err++; $display("FAIL lite_rd_hs: got ar=%0d r=%0d expected ar=1 r=2", c_ar - ar0, c_r - r0); end
    @(posedge clk); #1;
  endtask

  task automatic test_push();
    int lat; logic [31:0] rd, td_s; logic [2:0] tl_s; int s0, s1, s2;
    s0 = c_ss[0]; s1 = c_ss[1]; s2 = c_ss[2];
    fork
      wb_xfer(32'h3000_0184, 32'h7, 1'b1, 4'hF, lat, rd);
      begin
        @(posedge clk); #1; tl_s = ss_tlast; td_s = ss_tdata;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; ss_tready = 3'b010;
        @(posedge clk); #1; ss_tready = 3'b000;
      end
    join
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL push_lat: got %0d expected 5", lat); end
    n_cmp++; if (c_ss[1] - s1 !== 4) begin n_err++; $display("FAIL push_tvalid_cycles: got %0d expected 4", c_ss[1] - s1); end
    n_cmp++; if (tl_s !== 3'b010) begin n_err++; $display("FAIL push_tlast: got %b expected 010", tl_s); end
    n_cmp++; if (td_s !== 32'h7) begin n_err++; $display("FAIL push_tdata: got %h expected 00000007", td_s); end
    n_cmp++; if ((c_ss[0] - s0) + (c_ss[2] - s2) !== 0) begin n_err++; $display("FAIL push_other_lanes: got %0d expected 0", (c_ss[0] - s0) + (c_ss[2] - s2)); end
    @(posedge clk); #1;
  endtask

  task automatic test_pop();
    int lat; logic [31:0] rd; int m1, mo;
    m1 = c_sm[1]; mo = c_sm[0] + c_sm[2];
    sm_tdata = {32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
    fork
      wb_xfer(32'h3000_0180, 32'h0, 1'b0, 4'hF, lat, rd);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; sm_tvalid = 3'b010;
        @(posedge clk); #1; sm_tvalid = 3'b000;
      end
    join
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL pop_lat: got %0d expected 4", lat); end
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL pop_dat: got %h expected cafef00d", rd); end
    n_cmp++; if (c_sm[1] - m1 !== 1) begin n_err++; $display("FAIL pop_tready_pulse: got %0d expected 1", c_sm[1] - m1); end
    n_cmp++; if (c_sm[0] + c_sm[2] - mo !== 0) begin n_err++; $display("FAIL pop_other_lanes: got %0d expected 0", c_sm[0] + c_sm[2] - mo); end
    @(posedge clk); #1;
  endtask

  task automatic test_pop_timeout();
    int lat; logic [31:0] rd; int m0;
    sm_tdata = '0;
    m0 = c_sm[0] + c_sm[1] + c_sm[2];
    wb_xfer(32'h3000_0280, 32'h0, 1'b0, 4'hF, lat, rd);
    n_cmp++; if (lat !== 256) begin n_err++; $display("FAIL timeout_lat: got %0d expected 256", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL timeout_dat: got %h expected deadbeef", rd); end
    n_cmp++; if (c_sm[0] + c_sm[1] + c_sm[2] - m0 !== 0) begin n_err++; $display("FAIL timeout_tready: got %0d expected 0", c_sm[0] + c_sm[1] + c_sm[2] - m0); end
    @(posedge clk); #1;
    wb_xfer(32'h3000_0F00, 32'h0, 1'b0, 4'hF, lat, rd);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL stat_lat: got %0d expected 1", lat); end
    n_cmp++; if (rd !== 32'h0000_0040) begin n_err++; $display("FAIL stat_rd: got %h expected 00000040", rd); end
    @(posedge clk); #1;
    wb_xfer(32'h3000_0F00, 32'h0000_0040, 1'b1, 4'hF, lat, rd);
    @(posedge clk); #1;
    wb_xfer(32'h3000_0F00, 32'h0, 1'b0, 4'hF, lat, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL stat_clear: got %h expected 00000000", rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_unmapped();
    int lat; logic [31:0] rd; int h0;
    h0 = hs_total();
    wb_xfer(32'h3000_0500, 32'h0, 1'b0, 4'hF, lat, rd);
    @(posedge clk); #1;
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL unmapped_lat: got %0d expected 1", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_dat: got %h expected 00000000", rd); end
    n_cmp++; if (hs_total() - h0 !== 0) begin n_err++; $display("FAIL unmapped_hs: got %0d expected 0", hs_total() - h0); end
    h0 = hs_total();
    wb_xfer(32'h3000_0100, 32'h9, 1'b1, 4'h0, lat, rd);
    @(posedge clk); #1;
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sel0_lat: got %0d expected 1", lat); end
    n_cmp++; if (hs_total() - h0 !== 0) begin n_err++; $display("FAIL sel0_hs: got %0d expected 0", hs_total() - h0); end
  endtask

  task automatic test_reset_mid_push();
    int a0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0200; wbs_dat_i = 32'h9;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ss_tvalid !== 3'b100) begin n_err++; $display("FAIL mid_push_active: got %b expected 100", ss_tvalid); end
    a0 = c_ack;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ss_tvalid !== 3'b000) begin n_err++; $display("FAIL rst_tvalid: got %b expected 000", ss_tvalid); end
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, S_IDLE); end
    rst = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (c_ack - a0 !== 0) begin n_err++; $display("FAIL rst_no_ack: got %0d expected 0", c_ack - a0); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_lite_write();
    test_lite_read();
    test_push();
    test_pop();
    test_pop_timeout();
    test_unmapped();
    test_reset_mid_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_accel_sched.md
WB_ACCEL_SCHED -- requirements
Module: wb_accel_sched

Interface
REQ-001 SHALL have parameter MEM_DELAY, default 10, meaning the memory wait cycles before ack.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for any accelerator handshake.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 SHALL have Wishbone slave inputs wbs_cyc_i, wbs_stb_i, wbs_we_i (1 bit each), wbs_sel_i (4), wbs_adr_i (32) and wbs_dat_i (32).
REQ-006 SHALL have Wishbone slave outputs wbs_ack_o (1) and wbs_dat_o (32).
REQ-007 SHALL have memory port outputs mem_en (1), mem_we (4), mem_addr (32) and mem_wdata (32), plus input mem_rdata (32).
REQ-008 SHALL have AXI-Lite master port (FIR config):
- outputs awvalid, wvalid, arvalid, rready (1 each), awaddr and araddr (12), wdata (32);
- inputs awready, wready, arready, rvalid (1 each) and rdata (32).
REQ-009 SHALL have stream master to accelerators:
- outputs ss_tvalid (3), ss_tlast (3), ss_tdata (32, shared);
- input ss_tready (3).
REQ-010 SHALL have stream slave from accelerators: inputs sm_tvalid (3) and sm_tdata (96, 32 per lane); output sm_tready (3). Lane 0 is FIR, lane 1 is MM, lane 2 is QS.

Function
REQ-011 SHALL decode the request latched on acceptance as follows:
- adr[31:20]=0x380 -> MEM;
- adr[31:20]=0x300 with adr[11:8]=0 and adr[7]=0 -> LITE;
- adr[11:8] in {0,1,2}, otherwise -> STREAM lane adr[9:8];
- adr[11:8]=0xF -> STAT;
- anything else -> UNMAPPED.
REQ-012 SHALL accept a request in IDLE when cyc&stb are high and ack is low, latching adr, dat, we and sel.
REQ-013 SHALL use FSM states IDLE, MEM_WAIT, LITE_WR, LITE_AR, LITE_R, PUSH, POP and ACK; STAT and UNMAPPED go directly to ACK.
REQ-014 SHALL assert wbs_ack_o only in ACK, for exactly one cycle; ACK always returns to IDLE.
REQ-015 SHALL handle MEM as follows:
- mem_en is held high through MEM_WAIT;
- mem_we = sel when we is set, else 0;
- ack comes MEM_DELAY+1 cycles after acceptance;
- mem_rdata is captured on the last wait cycle.
REQ-016 SHALL handle LITE_WR by holding awvalid and wvalid independently until each handshakes, and leaving the state when both have completed.
REQ-017 SHALL handle LITE read as follows: arvalid until arready (LITE_AR), then rready until rvalid (LITE_R), with rdata captured on the rvalid cycle.
REQ-018 SHALL handle PUSH (write) by holding ss_tvalid[lane] until ss_tready[lane]; ss_tlast[lane] = latched adr[2].
REQ-019 SHALL handle POP (read) by pulsing sm_tready[lane] for one cycle on the first cycle sm_tvalid[lane] is high, and capturing sm_tdata[lane] in that cycle.
REQ-020 SHALL keep the valid/ready outputs of all non-selected lanes at 0 at all times.
REQ-021 SHALL apply a timeout in LITE_*/PUSH/POP:
- the wait counter reaching TIMEOUT drops all valid/ready outputs, returns data 0xDEADBEEF and goes to ACK;
- it sets sticky bit timeout[target], with target 0..2 for lanes and 3 for LITE.
REQ-022 SHALL return {busy, 23'b0, timeout[3:0], 4'h0} on a STAT read; a STAT write clears the timeout bits where wbs_dat_i[7:4]=1.
REQ-023 SHALL ack UNMAPPED accesses after one cycle with data 0 and no side effects.
REQ-024 SHALL drive wbs_dat_o with the captured data during ACK and with 0 otherwise.
REQ-025 SHALL ignore a write strobe sel=0 for PUSH/LITE, acking without a side effect.

Reset
REQ-026 SHALL on rst set the FSM to IDLE and set all valid/ready/ack/mem_en outputs, mem_we, the counters, the timeout bits and wbs_dat_o to 0.
REQ-027 SHALL, on rst during an in-flight transaction, abort it without ack, with every handshake output 0 from the next cycle.

Structure
REQ-028 SHALL place in package wb_accel_pkg:
- the state enum;
- the target enum (MEM, LITE, STREAM, STAT, UNMAPPED);
- the base-address constants 0x380 and 0x300;
- the lane indices;
- the 0xDEADBEEF constant.
REQ-029 SHALL implement one sub-module, wb_wait_counter (load, enable, terminal-count compare), shared by MEM_DELAY and the timeout.

Verification
REQ-030 SHALL verify: read 0x38000010 with mem_rdata=0x12345678 -> ack 11 cycles after acceptance, dat=0x12345678.
REQ-031 SHALL verify: write 0x30000000 data 0xA5 with awready 2 cycles before wready -> awvalid drops first, single ack, no lane activity.
REQ-032 SHALL verify: write 0x30000184 data 7 with ss_tready[1] after 3 cycles -> ss_tvalid[1] for 4 cycles, ss_tlast[1]=1, ack.
REQ-033 SHALL verify: read 0x30000280 with sm_tvalid[2] never high -> ack after TIMEOUT cycles, dat=0xDEADBEEF; then a STAT read returns 0x00000040.
REQ-034 SHALL verify: rst asserted mid-PUSH -> ss_tvalid=0 the next cycle, no ack, FSM in IDLE.
REQ-035 SHALL verify: read 0x30000500 -> ack after 1 cycle, dat=0, no handshake outputs toggled.
